tm1638_responder: RTL and testbench

Synthesizable TM1638 device-side model: the responder end of the strobe/clock/data serial link that the driver and `spi_fifo` initiate. It oversamples STB/CLK/DIO with the system clock and decodes data, address and display-control commands into a 16-byte display RAM. On a key-read command it drives 32 bits of key-scan data back on DIO. It stands in for the chip in closed-loop benches and in FPGA loopback builds, where a second FPGA pin set replaces a real TM1638 board.

---
 rtl/tm1638_responder_if.sv | 28 ++
 rtl/tm1638_responder.sv | 245 ++++++++++++++++++++++++
 tb/tb_tm1638_responder.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tm1638_responder_if.sv
// tm1638_responder_if: bundles the initiator-facing strobe/clock lines, the
// key-scan word and the decoded display state of the TM1638 responder.
// DIO is bidirectional and stays a direct port on the responder so that its
// tristate driver sits on a module boundary.
interface tm1638_responder_if;
  logic         i_SPI_Stb;
  logic         i_SPI_Clk;
  logic [31:0]  i_Keys;
  logic [127:0] o_Display_Ram;
  logic         o_Display_On;
  logic [2:0]   o_Brightness;
  logic         o_Write;
  logic [3:0]   o_Write_Addr;
  logic         o_Frame_Done;
  logic         o_Err;

  modport slave (
    input  i_SPI_Stb, i_SPI_Clk, i_Keys,
    output o_Display_Ram, o_Display_On, o_Brightness,
    output o_Write, o_Write_Addr, o_Frame_Done, o_Err
  );

  modport master (
    output i_SPI_Stb, i_SPI_Clk, i_Keys,
    input  o_Display_Ram, o_Display_On, o_Brightness,
    input  o_Write, o_Write_Addr, o_Frame_Done, o_Err
  );
endinterface

// File: rtl/tm1638_responder.sv
// tm1638_responder: device-side TM1638 model. Oversamples STB/CLK/DIO through
// SYNC_STAGES flops, decodes data/address/display-control commands into a
// 16-byte display RAM and returns the 32-bit key-scan word on a key read.
// Optional build macro: TM1638_RESPONDER_PROTOCOL_CHECK_EN enables o_Err.
module tm1638_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  tm1638_responder_if.slave bus,
  inout  wire               io_SPI_Dio
);

  typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, IGNORE} state_t;

  logic [SYNC_STAGES-1:0] stbSync_q, clkSync_q, dioSync_q;
  logic                   stbPrev_q, clkPrev_q;
  logic                   stbS, clkS, dioS;
  logic                   stbRise, stbFall, clkRise, clkFall;

  state_t      state_q, state_d;
  logic [7:0]  shift_q, shift_d, byteNext;
  logic [2:0]  bitCnt_q, bitCnt_d;
  logic        fixedAddr_q, fixedAddr_d;
  logic [3:0]  addr_q, addr_d;
  logic [31:0] keys_q, keys_d;
  logic [5:0]  rdCnt_q, rdCnt_d;
  logic        dioOe_q, dioOe_d, dioOut_q, dioOut_d;
  logic        displayOn_q, displayOn_d;
  logic [2:0]  bright_q, bright_d;
  logic        write_q, write_d;
  logic [3:0]  writeAddr_q, writeAddr_d;
  logic        frameDone_q, frameDone_d;
  logic [7:0]  ram_q [16];
  logic [127:0] ramFlat;

  // Synchronizers and previous-value flops; STB resets to its active level so
  // a reset released mid-frame cannot fake a fall and join a frame halfway.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      stbSync_q <= '0;
      clkSync_q <= '1;
      dioSync_q <= '1;
      stbPrev_q <= 1'b0;
      clkPrev_q <= 1'b1;
    end else begin
      stbSync_q <= {stbSync_q[SYNC_STAGES-2:0], bus.i_SPI_Stb};
      clkSync_q <= {clkSync_q[SYNC_STAGES-2:0], bus.i_SPI_Clk};
      dioSync_q <= {dioSync_q[SYNC_STAGES-2:0], io_SPI_Dio};
      stbPrev_q <= stbS;
      clkPrev_q <= clkS;
    end
  end

  assign stbS     = stbSync_q[SYNC_STAGES-1];
  assign clkS     = clkSync_q[SYNC_STAGES-1];
  assign dioS     = dioSync_q[SYNC_STAGES-1];
  assign stbRise  = stbS & ~stbPrev_q;
  assign stbFall  = ~stbS & stbPrev_q;
  assign clkRise  = clkS & ~clkPrev_q;
  assign clkFall  = ~clkS & clkPrev_q;
  assign byteNext = {dioS, shift_q[7:1]};

  // Next-state and datapath decode; an STB rise outranks any clock edge seen
  // in the same cycle, so a bit arriving with the strobe is dropped.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bitCnt_d    = bitCnt_q;
    fixedAddr_d = fixedAddr_q;
    addr_d      = addr_q;
    keys_d      = keys_q;
    rdCnt_d     = rdCnt_q;
    dioOe_d     = dioOe_q;
    dioOut_d    = dioOut_q;
    displayOn_d = displayOn_q;
    bright_d    = bright_q;
    write_d     = 1'b0;
    writeAddr_d = writeAddr_q;
    frameDone_d = 1'b0;
    if (stbRise && state_q != IDLE) begin
      state_d     = IDLE;
      dioOe_d     = 1'b0;
      bitCnt_d    = '0;
      frameDone_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (stbFall) begin
            state_d  = CMD;
            bitCnt_d = '0;
          end
        end
        CMD: begin
          if (clkRise) begin
            shift_d  = byteNext;
            bitCnt_d = bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) begin
              unique case (byteNext[7:6])
                2'b01: begin
                  fixedAddr_d = byteNext[2];
                  if (byteNext[1]) begin
                    keys_d  = bus.i_Keys;
                    rdCnt_d = '0;
                    state_d = RDATA;
                  end else begin
                    state_d = IGNORE;
                  end
                end
                2'b11: begin
                  addr_d  = byteNext[3:0];
                  state_d = WDATA;
                end
                2'b10: begin
                  displayOn_d = byteNext[3];
                  bright_d    = byteNext[2:0];
                  state_d     = IGNORE;
                end
                default: state_d = IGNORE;
              endcase
            end
          end
        end
        WDATA: begin
          if (clkRise) begin
            shift_d  = byteNext;
            bitCnt_d = bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) begin
              write_d     = 1'b1;
              writeAddr_d = addr_q;
              if (!fixedAddr_q) addr_d = addr_q + 4'd1;
            end
          end
        end
        RDATA: begin
          if (clkFall) begin
            if (rdCnt_q < 6'd32) begin
              dioOe_d  = 1'b1;
              dioOut_d = keys_q[rdCnt_q[4:0]];
              rdCnt_d  = rdCnt_q + 6'd1;
            end else if (rdCnt_q == 6'd32) begin
              dioOe_d = 1'b0;
              rdCnt_d = 6'd33;
            end
          end
        end
        IGNORE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Datapath, mode, display-control and pulse registers.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      shift_q     <= '0;
      bitCnt_q    <= '0;
      fixedAddr_q <= 1'b0;
      addr_q      <= '0;
      keys_q      <= '0;
      rdCnt_q     <= '0;
      dioOe_q     <= 1'b0;
      dioOut_q    <= 1'b0;
      displayOn_q <= 1'b0;
      bright_q    <= '0;
      write_q     <= 1'b0;
      writeAddr_q <= '0;
      frameDone_q <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      bitCnt_q    <= bitCnt_d;
      fixedAddr_q <= fixedAddr_d;
      addr_q      <= addr_d;
      keys_q      <= keys_d;
      rdCnt_q     <= rdCnt_d;
      dioOe_q     <= dioOe_d;
      dioOut_q    <= dioOut_d;
      displayOn_q <= displayOn_d;
      bright_q    <= bright_d;
      write_q     <= write_d;
      writeAddr_q <= writeAddr_d;
      frameDone_q <= frameDone_d;
    end
  end

  // Display RAM, written in the same cycle the write pulse is registered.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      for (int i = 0; i < 16; i++) ram_q[i] <= '0;
    end else if (write_d) begin
      ram_q[addr_q] <= byteNext;
    end
  end

  // Flatten the RAM so byte a lands on bits [8a+7:8a].
  always_comb begin
    ramFlat = '0;
    for (int a = 0; a < 16; a++) ramFlat[8*a +: 8] = ram_q[a];
  end

  assign io_SPI_Dio        = dioOe_q ? dioOut_q : 1'bz;
  assign bus.o_Display_Ram = ramFlat;
  assign bus.o_Display_On  = displayOn_q;
  assign bus.o_Brightness  = bright_q;
  assign bus.o_Write       = write_q;
  assign bus.o_Write_Addr  = writeAddr_q;
  assign bus.o_Frame_Done  = frameDone_q;

`ifdef TM1638_RESPONDER_PROTOCOL_CHECK_EN
  logic errEvent;
  logic err_q;

  // Flag partial bytes at STB rise, 00 commands, read clocks past the end and clocks while ignoring.
  always_comb begin
    errEvent = 1'b0;
    if (stbRise && state_q != IDLE) begin
      errEvent = (state_q == CMD || state_q == WDATA) && (bitCnt_q != 3'd0);
    end else begin
      unique case (state_q)
        CMD:     errEvent = clkRise && (bitCnt_q == 3'd7) && (byteNext[7:6] == 2'b00);
        RDATA:   errEvent = clkFall && (rdCnt_q == 6'd33);
        IGNORE:  errEvent = clkRise;
        default: errEvent = 1'b0;
      endcase
    end
  end

  // Register the error pulse.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) err_q <= 1'b0;
    else          err_q <= errEvent;
  end

  assign bus.o_Err = err_q;
`else
  assign bus.o_Err = 1'b0;
`endif

endmodule

// File: tb/tb_tm1638_responder.sv
// tb_tm1638_responder: drives TM1638 frames from the initiator side and
// compares the responder against a byte-level reference model.
module tb_tm1638_responder;
  localparam int H = 6;
`ifdef TM1638_RESPONDER_PROTOCOL_CHECK_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tbDrive = 1'b0;
  logic tbDioVal = 1'b1;
  wire  dio;

  tm1638_responder_if bus();

  pullup(dio);
  assign dio = tbDrive ? tbDioVal : 1'bz;

  tm1638_responder #(.SYNC_STAGES(2)) dut (
    .i_Clk      (clk),
    .i_Rst_n    (rst_n),
    .bus        (bus),
    .io_SPI_Dio (dio)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int frameCnt = 0;
  int errCnt = 0;
  int wrQ[$];

  // Reference model state
  logic [7:0] mRam [16];
  int   mAddr, expFrames, expErr;
  logic mFixed, mOn;
  logic [2:0] mBright;
  int   expWr[$];
  logic [7:0] txQ[$];

  // Record pulse outputs away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_Write) wrQ.push_back(int'(bus.o_Write_Addr));
      if (bus.o_Frame_Done) frameCnt++;
      if (bus.o_Err) errCnt++;
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got %h required %h", tag, got, exp);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) mRam[i] = 8'h00;
    mAddr = 0; mFixed = 1'b0; mOn = 1'b0; mBright = 3'd0;
    expWr.delete();
  endtask

  function automatic logic [127:0] modelFlat();
    logic [127:0] r;
    for (int a = 0; a < 16; a++) r[8*a +: 8] = mRam[a];
    return r;
  endfunction

  // Apply the command-level rules to the bytes of one complete frame.
  task automatic modelFrame();
    logic [7:0] cmd;
    cmd = txQ[0];
    case (cmd[7:6])
      2'b01: mFixed = cmd[2];
      2'b10: begin mOn = cmd[3]; mBright = cmd[2:0]; end
      2'b11: begin
        mAddr = int'(cmd[3:0]);
        for (int i = 1; i < txQ.size(); i++) begin
          mRam[mAddr] = txQ[i];
          expWr.push_back(mAddr);
          if (!mFixed) mAddr = (mAddr + 1) % 16;
        end
      end
      default: expErr += ERR_EN;
    endcase
    expFrames++;
  endtask

  task automatic sendBits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      bus.i_SPI_Clk = 1'b0; tbDrive = 1'b1; tbDioVal = b[i];
      waitCycles(H);
      bus.i_SPI_Clk = 1'b1;
      waitCycles(H);
    end
  endtask

  task automatic stbLow();
    bus.i_SPI_Stb = 1'b0;
    waitCycles(H);
  endtask

  task automatic stbHigh();
    tbDrive = 1'b0;
    bus.i_SPI_Clk = 1'b1;
    bus.i_SPI_Stb = 1'b1;
    waitCycles(3 * H);
  endtask

  // Send txQ as one frame and update the model.
  task automatic applyStimulus();
    stbLow();
    foreach (txQ[i]) sendBits(txQ[i], 8);
    stbHigh();
    modelFrame();
  endtask

  task automatic compareFrame(input string tag);
    checkOutput({tag, ".ram"}, bus.o_Display_Ram, modelFlat());
    checkOutput({tag, ".wrCount"}, wrQ.size(), expWr.size());
    for (int i = 0; i < wrQ.size() && i < expWr.size(); i++)
      checkOutput({tag, ".wrAddr"}, wrQ[i], expWr[i]);
    wrQ.delete(); expWr.delete();
    checkOutput({tag, ".frames"}, frameCnt, expFrames);
    checkOutput({tag, ".dispOn"}, bus.o_Display_On, mOn);
    checkOutput({tag, ".bright"}, bus.o_Brightness, mBright);
    checkOutput({tag, ".err"}, errCnt, expErr);
  endtask

  // Key-read frame: command, 32 read clocks, one releasing fall, STB rise.
  task automatic readFrame(input logic [7:0] cmd, input logic [31:0] keys, output logic [31:0] w);
    bus.i_Keys = keys;
    stbLow();
    sendBits(cmd, 8);
    tbDrive = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bus.i_SPI_Clk = 1'b0; waitCycles(H);
      w[i] = dio;
      bus.i_SPI_Clk = 1'b1; waitCycles(H);
    end
    bus.i_SPI_Clk = 1'b0; waitCycles(H);
    checkOutput("read.releaseAfter32", dio, 1'b1);
    bus.i_SPI_Clk = 1'b1; waitCycles(H);
    stbHigh();
    checkOutput("read.releaseAfterStb", dio, 1'b1);
    mFixed = cmd[2];
    expFrames++;
  endtask

  initial begin
    logic [31:0] w;
    logic [7:0]  expB [4];
    int n;
    bus.i_SPI_Stb = 1'b1; bus.i_SPI_Clk = 1'b1; bus.i_Keys = '0;
    expFrames = 0; expErr = 0;
    modelReset();

    // Reset
    waitCycles(4);
    checkOutput("rst.ram", bus.o_Display_Ram, 128'h0);
    checkOutput("rst.dispOn", bus.o_Display_On, 1'b0);
    checkOutput("rst.bright", bus.o_Brightness, 3'd0);
    checkOutput("rst.write", bus.o_Write, 1'b0);
    checkOutput("rst.wrAddr", bus.o_Write_Addr, 4'd0);
    checkOutput("rst.frameDone", bus.o_Frame_Done, 1'b0);
    checkOutput("rst.err", bus.o_Err, 1'b0);
    checkOutput("rst.dio", dio, 1'b1);
    rst_n = 1'b1;
    waitCycles(10);
    checkOutput("rst.framesAfter", frameCnt, 0);

    // Auto-increment burst
    txQ = '{8'h40}; applyStimulus();
    txQ = '{8'hC0, 8'h3F, 8'h06, 8'h5B}; applyStimulus();
    checkOutput("burst.ram", bus.o_Display_Ram[23:0], 24'h5B063F);
    compareFrame("burst");

    // Fixed address, then wrap
    txQ = '{8'h44}; applyStimulus();
    txQ = '{8'hC5, 8'hAA}; applyStimulus();
    checkOutput("fixed.ram5", bus.o_Display_Ram[47:40], 8'hAA);
    compareFrame("fixed");
    txQ = '{8'h40}; applyStimulus();
    txQ = '{8'hCF, 8'h11, 8'h22}; applyStimulus();
    checkOutput("wrap.ram15", bus.o_Display_Ram[127:120], 8'h11);
    checkOutput("wrap.ram0", bus.o_Display_Ram[7:0], 8'h22);
    compareFrame("wrap");

    // Display control
    txQ = '{8'h8A}; applyStimulus();
    checkOutput("disp.on", bus.o_Display_On, 1'b1);
    checkOutput("disp.bright", bus.o_Brightness, 3'd2);
    compareFrame("disp");

    // Key read
    readFrame(8'h42, 32'h80402001, w);
    expB[0] = 8'h01; expB[1] = 8'h20; expB[2] = 8'h40; expB[3] = 8'h80;
    for (int k = 0; k < 4; k++) checkOutput($sformatf("read.byte%0d", k), w[8*k +: 8], expB[k]);
    compareFrame("read");

    // Abort after 5 bits of a data byte
    stbLow();
    sendBits(8'hC3, 8);
    sendBits(8'h5A, 5);
    stbHigh();
    mAddr = 3; expFrames++; expErr += ERR_EN;
    compareFrame("abort");

    // Command 00
    txQ = '{8'h05}; applyStimulus();
    compareFrame("cmd00");

    // Randomized frames
    for (int it = 0; it < 24; it++) begin
      case ($urandom_range(0, 3))
        0: begin txQ = '{8'h40 | (8'($urandom_range(0, 1)) << 2)}; applyStimulus(); end
        1: begin
          txQ = '{8'hC0 | 8'($urandom_range(0, 15))};
          n = $urandom_range(1, 5);
          for (int i = 0; i < n; i++) txQ.push_back(8'($urandom));
          applyStimulus();
        end
        2: begin txQ = '{8'h80 | 8'($urandom_range(0, 15))}; applyStimulus(); end
        default: begin
          logic [31:0] keys;
          keys = $urandom & 32'h7FFF_FFFF;
          readFrame(8'h42 | (8'($urandom_range(0, 1)) << 2), keys, w);
          checkOutput("rand.keys", w, keys);
        end
      endcase
      compareFrame("rand");
    end

    // Reset asserted mid-read
    stbLow();
    bus.i_Keys = 32'h0;
    sendBits(8'h42, 8);
    tbDrive = 1'b0;
    bus.i_SPI_Clk = 1'b0; waitCycles(H);
    checkOutput("midRst.driving", dio, 1'b0);
    rst_n = 1'b0;
    waitCycles(1);
    checkOutput("midRst.released", dio, 1'b1);
    checkOutput("midRst.ram", bus.o_Display_Ram, 128'h0);
    bus.i_SPI_Clk = 1'b1; waitCycles(2);
    rst_n = 1'b1; waitCycles(2);
    stbHigh();
    modelReset();
    wrQ.delete();

    // Recovery write after reset: auto-increment from address 0
    txQ = '{8'hC0, 8'hA5, 8'h3C}; applyStimulus();
    checkOutput("recover.ram", bus.o_Display_Ram, modelFlat());
    checkOutput("recover.wrCount", wrQ.size(), expWr.size());
    for (int i = 0; i < wrQ.size() && i < expWr.size(); i++)
      checkOutput("recover.wrAddr", wrQ[i], expWr[i]);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
